// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the sequential shift-add multiplier:
//   state_t  - control FSM states (IDLE, RUN, FIX, DONE)
//   cnt_w()  - width of the RUN-cycle counter for a given operand width
// ---------------------------------------------------------------------------
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Counter width able to hold 0 .. width-1.
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/mult_add_row.sv
// ---------------------------------------------------------------------------
// mult_add_row
// WIDTH-bit ripple-carry adder built from a full-adder chain. The multiplier
// reuses this single row every RUN cycle to add one partial product.
// Ports:
//   x, y  in   WIDTH  addends
//   sum   out  WIDTH  x + y, low WIDTH bits
//   cout  out  1      carry out of the top bit
// ---------------------------------------------------------------------------
module mult_add_row
  import mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry_s;

  assign carry_s[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]       = x[i] ^ y[i] ^ carry_s[i];
    assign carry_s[i+1] = (x[i] & y[i]) | (carry_s[i] & (x[i] ^ y[i]));
  end

  assign cout = carry_s[WIDTH];

endmodule

// File: rtl/mult_seq_shift_add.sv
// ---------------------------------------------------------------------------
// mult_seq_shift_add
// Sequential shift-add multiplier, one partial-product row per cycle, with
// valid/ready handshakes and signed/unsigned mode. Signed operands are
// converted to magnitudes on accept, multiplied unsigned, and the product is
// negated in the FIX cycle when the operand signs differ.
// Ports:
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   in_valid   in   1        operands/mode presented
//   in_ready   out  1        operands accepted (high only in IDLE)
//   is_signed  in   1        1 = two's complement, 0 = unsigned
//   a, b       in   WIDTH    multiplicand, multiplier
//   out_valid  out  1        product valid, held until taken
//   out_ready  in   1        consumer takes the product
//   product    out  2*WIDTH  registered result
//   busy       out  1        high in RUN, FIX or DONE
// ---------------------------------------------------------------------------
module mult_seq_shift_add
  import mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int                 CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   W_ZERO   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] P_ZERO   = {(2*WIDTH){1'b0}};
  localparam logic [2*WIDTH-1:0] P_ONE    = {{(2*WIDTH-1){1'b0}}, 1'b1};

  state_t             state_r;
  state_t             state_nx_s;

  // The upper accumulator half is conceptually WIDTH+1 bits, but after every
  // right shift its top bit is zero, so only WIDTH bits are stored; the
  // adder carry enters the shifted value directly.
  logic [WIDTH-1:0]   acc_hi_r;
  logic [WIDTH-1:0]   acc_lo_r;
  logic [WIDTH-1:0]   a_mag_r;
  logic               neg_r;
  logic [CNT_W-1:0]   cnt_r;

  logic               accept_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic               neg_s;
  logic [WIDTH-1:0]   addend_s;
  logic [WIDTH-1:0]   row_sum_s;
  logic               row_cout_s;
  logic [2*WIDTH-1:0] mag_s;
  logic [2*WIDTH-1:0] result_s;

  logic               in_ready_r;
  logic               busy_r;
  logic               out_valid_r;
  logic [2*WIDTH-1:0] product_r;

  assign accept_s = (state_r == IDLE) && in_valid;

  // Single adder row shared by all RUN cycles.
  mult_add_row #(
    .WIDTH (WIDTH)
  ) u_add_row (
    .x    (acc_hi_r),
    .y    (addend_s),
    .sum  (row_sum_s),
    .cout (row_cout_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_nx_s = RUN;
        else          state_nx_s = IDLE;
      end
      RUN: begin
        if (cnt_r == CNT_LAST) state_nx_s = FIX;
        else                   state_nx_s = RUN;
      end
      FIX: begin
        state_nx_s = DONE;
      end
      DONE: begin
        if (out_ready) state_nx_s = IDLE;
        else           state_nx_s = DONE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Sign-magnitude conversion of the incoming operands and final sign fix.
  // The magnitude of the most negative value is representable unsigned.
  always_comb begin
    a_mag_s  = a;
    b_mag_s  = b;
    neg_s    = 1'b0;
    addend_s = W_ZERO;
    if (is_signed && a[WIDTH-1]) a_mag_s = ~a + W_ONE;
    else                         a_mag_s = a;
    if (is_signed && b[WIDTH-1]) b_mag_s = ~b + W_ONE;
    else                         b_mag_s = b;
    neg_s = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
    if (acc_lo_r[0]) addend_s = a_mag_r;
    else             addend_s = W_ZERO;
  end

  assign mag_s    = {acc_hi_r, acc_lo_r};
  assign result_s = neg_r ? (~mag_s + P_ONE) : mag_s;

  // Accumulator, multiplicand magnitude, sign flag and RUN counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi_r <= W_ZERO;
      acc_lo_r <= W_ZERO;
      a_mag_r  <= W_ZERO;
      neg_r    <= 1'b0;
      cnt_r    <= CNT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            acc_hi_r <= W_ZERO;
            acc_lo_r <= b_mag_s;
            a_mag_r  <= a_mag_s;
            neg_r    <= neg_s;
            cnt_r    <= CNT_ZERO;
          end else begin
            cnt_r    <= cnt_r;
          end
        end
        RUN: begin
          // {sum, acc_lo} >> 1 with sum = {cout, row_sum}
          acc_hi_r <= {row_cout_s, row_sum_s[WIDTH-1:1]};
          acc_lo_r <= {row_sum_s[0], acc_lo_r[WIDTH-1:1]};
          cnt_r    <= cnt_r + CNT_ONE;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Result register; only the FIX cycle writes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_r <= P_ZERO;
    end else if (state_r == FIX) begin
      product_r <= result_s;
    end else begin
      product_r <= product_r;
    end
  end

  // Handshake/status flags registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= (state_nx_s == IDLE);
      busy_r      <= (state_nx_s != IDLE);
      out_valid_r <= (state_nx_s == DONE);
    end
  end

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign product   = product_r;

endmodule

// File: tb/tb_mult_seq_shift_add.sv
// ---------------------------------------------------------------------------
// tb_mult_seq_shift_add
// Self-checking bench: a WIDTH=4 instance for directed corner cases and a
// WIDTH=8 instance for randomized traffic against an arithmetic model.
// ---------------------------------------------------------------------------
module tb_mult_seq_shift_add;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       in_valid4, in_ready4, is_signed4, out_valid4, out_ready4, busy4;
  logic [3:0] a4, b4;
  logic [7:0] product4;

  logic        in_valid8, in_ready8, is_signed8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mult_seq_shift_add #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .is_signed(is_signed4), .a(a4), .b(b4), .out_valid(out_valid4),
    .out_ready(out_ready4), .product(product4), .busy(busy4)
  );

  mult_seq_shift_add #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .is_signed(is_signed8), .a(a8), .b(b8), .out_valid(out_valid8),
    .out_ready(out_ready8), .product(product8), .busy(busy8)
  );

  // Golden model: plain integer multiply of the interpreted operands,
  // reduced modulo 2^(2w).
  function automatic longint ref_prod(input bit s, input int w, input longint x, input longint y);
    longint sx, sy, p;
    sx = x;
    sy = y;
    if (s && x[w-1]) sx = x - (longint'(1) << w);
    if (s && y[w-1]) sy = y - (longint'(1) << w);
    p = sx * sy;
    return p & ((longint'(1) << (2 * w)) - longint'(1));
  endfunction

  // One complete WIDTH=4 transaction: present, wait for result, take it.
  task automatic run_op4(input bit s, input logic [3:0] x, input logic [3:0] y,
                         output logic [7:0] p, output int lat);
    @(negedge clk);
    is_signed4 = s; a4 = x; b4 = y; in_valid4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
    lat = 0;
    while (out_valid4 !== 1'b1 && lat < 20) begin
      checks++;
      if (in_ready4 !== 1'b0 || busy4 !== 1'b1) begin
        failures++;
        $display("FAIL busy_flags4: in_ready=%b busy=%b required in_ready=0 busy=1", in_ready4, busy4);
      end
      @(negedge clk);
      lat++;
    end
    p = product4;
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
    checks++;
    if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
      failures++;
      $display("FAIL release4: in_ready=%b out_valid=%b required 1/0", in_ready4, out_valid4);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready4, out_valid4, busy4} !== 3'b100 || product4 !== 8'h00) begin
      failures++;
      $display("FAIL reset4: rdy/ov/busy=%b product=%h required 100 / 00", {in_ready4, out_valid4, busy4}, product4);
    end
    checks++;
    if ({in_ready8, out_valid8, busy8} !== 3'b100 || product8 !== 16'h0000) begin
      failures++;
      $display("FAIL reset8: rdy/ov/busy=%b product=%h required 100 / 0000", {in_ready8, out_valid8, busy8}, product8);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned_max();
    logic [7:0] p;
    int lat;
    run_op4(1'b0, 4'd15, 4'd15, p, lat);
    checks++;
    if (p !== 8'hE1) begin
      failures++;
      $display("FAIL umax_product: got %h required e1", p);
    end
    checks++;
    if (lat != 5) begin
      failures++;
      $display("FAIL umax_latency: got %0d required 5", lat);
    end
  endtask

  task automatic test_signed_corners();
    logic [3:0] ta [4] = '{4'h8, 4'h8, 4'hF, 4'h0};
    logic [3:0] tb [4] = '{4'h8, 4'h7, 4'h1, 4'h8};
    logic [7:0] te [4] = '{8'h40, 8'hC8, 8'hFF, 8'h00};
    logic [7:0] p;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op4(1'b1, ta[i], tb[i], p, lat);
      checks++;
      if (p !== te[i]) begin
        failures++;
        $display("FAIL signed_product[%0d]: got %h required %h", i, p, te[i]);
      end
      checks++;
      if (lat != 5) begin
        failures++;
        $display("FAIL signed_latency[%0d]: got %0d required 5", i, lat);
      end
    end
  endtask

  task automatic test_hold_ignore();
    int lat;
    @(negedge clk);
    is_signed4 = 1'b0; a4 = 4'd6; b4 = 4'd7; in_valid4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
    lat = 0;
    while (out_valid4 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 5) begin
      failures++;
      $display("FAIL hold_first_latency: got %0d required 5", lat);
    end
    // Stall the consumer while pulsing new operands that must be ignored.
    for (int i = 0; i < 10; i++) begin
      in_valid4 = (i % 2 == 0); is_signed4 = 1'b1; a4 = 4'd9; b4 = 4'd9;
      @(negedge clk);
      checks++;
      if (product4 !== 8'h2A || out_valid4 !== 1'b1 || in_ready4 !== 1'b0) begin
        failures++;
        $display("FAIL hold_stable[%0d]: product=%h ov=%b rdy=%b required 2a/1/0", i, product4, out_valid4, in_ready4);
      end
    end
    in_valid4 = 1'b1; is_signed4 = 1'b0; a4 = 4'd9; b4 = 4'd9;
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
    checks++;
    if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || product4 !== 8'h2A) begin
      failures++;
      $display("FAIL hold_take: rdy=%b ov=%b product=%h required 1/0/2a", in_ready4, out_valid4, product4);
    end
    @(negedge clk);
    in_valid4 = 1'b0;
    checks++;
    if (in_ready4 !== 1'b0) begin
      failures++;
      $display("FAIL hold_second_accept: in_ready=%b required 0", in_ready4);
    end
    lat = 0;
    while (out_valid4 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 5 || product4 !== 8'h51) begin
      failures++;
      $display("FAIL hold_second_result: latency=%0d product=%h required 5 / 51", lat, product4);
    end
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
  endtask

  task automatic test_reset_midrun();
    logic [7:0] p;
    int lat;
    @(negedge clk);
    is_signed4 = 1'b0; a4 = 4'd7; b4 = 4'd7; in_valid4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready4, out_valid4, busy4} !== 3'b100 || product4 !== 8'h00) begin
      failures++;
      $display("FAIL midrun_reset: rdy/ov/busy=%b product=%h required 100 / 00", {in_ready4, out_valid4, busy4}, product4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op4(1'b0, 4'd3, 4'd5, p, lat);
    checks++;
    if (p !== 8'h0F || lat != 5) begin
      failures++;
      $display("FAIL after_reset_op: product=%h latency=%0d required 0f / 5", p, lat);
    end
  endtask

  task automatic test_random8();
    logic [15:0] exp_q [$];
    int          acc_q [$];
    int          cyc = 0;
    int          accepted = 0;
    int          taken = 0;
    bit          prev_ov = 1'b0;
    bit          take;
    while (cyc < 70000 && !(accepted == 2000 && exp_q.size() == 0)) begin
      @(negedge clk);
      cyc++;
      // Observe what the last edge produced.
      if (out_valid8 === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rand_spurious: out_valid with no outstanding operation at cycle %0d", cyc);
        end else begin
          if (product8 !== exp_q[0]) begin
            failures++;
            $display("FAIL rand_product: got %h required %h at cycle %0d", product8, exp_q[0], cyc);
          end
          if (!prev_ov) begin
            checks++;
            if (cyc - acc_q[0] != 9) begin
              failures++;
              $display("FAIL rand_latency: got %0d required 9", cyc - acc_q[0]);
            end
          end
        end
      end
      // Drive the next cycle's inputs.
      out_ready8 = ($urandom_range(0, 9) < 6);
      in_valid8  = (accepted < 2000) && ($urandom_range(0, 1) == 1);
      a8         = 8'($urandom);
      b8         = 8'($urandom);
      is_signed8 = 1'($urandom_range(0, 1));
      if (in_valid8 && in_ready8 === 1'b1) begin
        exp_q.push_back(16'(ref_prod(is_signed8, 8, longint'(a8), longint'(b8))));
        acc_q.push_back(cyc + 1);
        accepted++;
      end
      take = (out_valid8 === 1'b1) && out_ready8 && (exp_q.size() != 0);
      if (take) begin
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
        taken++;
      end
      prev_ov = (out_valid8 === 1'b1) && !take;
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b0;
    checks++;
    if (accepted != 2000 || taken != 2000 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL rand_drain: accepted=%0d taken=%0d outstanding=%0d required 2000/2000/0", accepted, taken, exp_q.size());
    end
  endtask

  initial begin
    in_valid4 = 1'b0; is_signed4 = 1'b0; a4 = 4'd0; b4 = 4'd0; out_ready4 = 1'b0;
    in_valid8 = 1'b0; is_signed8 = 1'b0; a8 = 8'd0; b8 = 8'd0; out_ready8 = 1'b0;
    test_reset();
    test_unsigned_max();
    test_signed_corners();
    test_hold_ignore();
    test_reset_midrun();
    test_random8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_seq_shift_add.md
# mult_seq_shift_add

Parametrised sequential shift-add multiplier with a valid/ready handshake and selectable signed or unsigned mode. It is the clocked, width-generic successor to our fixed 4x4 combinational array multiplier. It computes one partial-product row per cycle through a single reused adder row, trading latency for area. It sits behind the tile's I/O wrapper, or any other datapath master, and holds its result until the consumer takes it.

## Interface
- `WIDTH`, default 4: operand width in bits; must be ≥ 2. The product is 2·WIDTH bits.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands and mode are presented.
- `in_ready`  out  1  block can accept operands; high only in IDLE.
- `is_signed`  in  1  1 = two's-complement operands and product; 0 = unsigned. Sampled on accept.
- `a`  in  WIDTH  multiplicand.
- `b`  in  WIDTH  multiplier.
- `out_valid`  out  1  `product` is valid; held until taken.
- `out_ready`  in  1  consumer takes the result.
- `product`  out  2·WIDTH  registered result.
- `busy`  out  1  high in RUN, FIX or DONE.

## Operation
- States:
  - IDLE: `in_ready`=1. `in_valid` moves to RUN.
  - RUN: exactly WIDTH cycles, then FIX.
  - FIX: one cycle, then DONE.
  - DONE: `out_valid`=1. `out_ready` moves to IDLE.
- Accept (IDLE and `in_valid`):
  - `a_mag` = (`is_signed` and a[MSB]) ? −a : a; `b_mag` likewise. Both are WIDTH-bit unsigned.
  - `neg` = `is_signed` and (a[MSB] xor b[MSB]).
  - acc_hi ← 0 (WIDTH+1 bits), acc_lo ← `b_mag`, cnt ← 0.
- RUN, each cycle:
  - sum = acc_hi + (acc_lo[0] ? `a_mag` : 0), WIDTH+1 bits, no overflow possible.
  - {acc_hi, acc_lo} ← {sum, acc_lo} >> 1.
  - cnt ← cnt+1; leave RUN when cnt = WIDTH−1.
- FIX: `product` ← `neg` ? −{acc_hi[WIDTH−1:0], acc_lo} : {acc_hi[WIDTH−1:0], acc_lo}, mod 2^(2·WIDTH). Set `out_valid`.
- The magnitude of −2^(WIDTH−1) is 2^(WIDTH−1) and fits unsigned. Signed products therefore always fit 2·WIDTH bits: (−8)·(−8) = +64 for WIDTH=4. Unsigned max (2^W−1)² also fits.
- No early termination: zero operands still take the full latency.
- `in_valid` while not IDLE is ignored and has no side effects. Operands are not re-sampled after accept.
- `product` changes only in FIX. It holds the last result through IDLE and the next RUN.

## Timing
- Reset (async assert, sync release): state=IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `product`=0, internal acc/cnt=0.
- Accept at edge E0. RUN spans edges E1..E_WIDTH. FIX occurs at edge E_WIDTH+1, after which `out_valid`=1 and `product` are stable. Latency is WIDTH+1 cycles from accept to `out_valid`.
- `out_ready` high in the cycle `out_valid` first rises: result taken at that edge, IDLE next cycle.
- `out_ready` is ignored outside DONE.
- Back-to-back minimum period is WIDTH+3 cycles. IDLE always lasts at least one cycle; there is no same-cycle release and accept.
- `rst_n` asserted in any state immediately forces the reset values and discards the operation in flight. After release, the first accept behaves normally.

## Structure
- Shared package `mult_pkg`:
  - state enum {IDLE, RUN, FIX, DONE}.
  - function `cnt_w(WIDTH)` = $clog2(WIDTH).
- Sub-module `mult_add_row`: WIDTH-bit ripple adder with carry-out, built as a full-adder chain in the team's existing style. It is instantiated once and reused every RUN cycle.
- Top: FSM, counter, acc shift register, sign-magnitude pre/post logic.

## Test plan
- WIDTH=4, unsigned, a=15, b=15 → `product`=0x00E1. `out_valid` rises exactly 5 cycles after accept; `in_ready`=0 throughout.
- WIDTH=4, signed: −8·−8 → 0x40; −8·7 → 0xC8; −1·1 → 0xFF; 0·−8 → 0x00. Each has latency 5.
- WIDTH=4, hold `out_ready`=0 for 10 cycles after `out_valid`, pulsing `in_valid` with other operands → `product` stable and second operands ignored. On `out_ready`=1 → IDLE next cycle, then the second op is accepted.
- Assert `rst_n` low in RUN cycle 2 → all outputs at reset values without waiting for a clock edge. After release, 3·5 unsigned → 0x0F with normal latency.
- WIDTH=8, 2000 random operand pairs, both modes, random `in_valid`/`out_ready` stalls → every result matches the golden model; latency always 9; no dropped or duplicated results.
